ad7265_responder: RTL and testbench
===================================

// Module: ad7265_responder
// PURPOSE
//  Synthesizable AD7265 dual-ADC serial responder: the device end of the interface driven by adc_temps_if.
//  Samples adc_sclk/ncs/adc_addr/rng on the system clock and shifts per-channel 12-bit words out on douta/doutb.
//  Used on the emulator/loopback build to stand in for the temperature ADC in closed-loop hardware tests.
//  Channel words are loaded through a simple write port from the register bank.
// PARAMETERS
//  LEAD_ZEROS  2   zero bits shifted before the 12-bit word (1..4)
//  SYNC_STAGES 2   synchronizer depth on adc_sclk, ncs, adc_addr, rng (>=2)
// PORTS
//  clock        in   1   system clock (20 MHz), the only clock
//  reset_n      in   1   asynchronous, active-low reset
//  wr_en        in   1   write strobe for channel word table, one clock wide
//  wr_side      in   1   0 = side A table, 1 = side B table
//  wr_addr      in   3   channel index 0..7
//  wr_data      in   12  channel word
//  adc_sclk     in   1   serial clock from initiator (asynchronous to clock)
//  ncs          in   1   active-low chip select from initiator
//  adc_addr     in   3   channel select from initiator
//  rng          in   1   range select from initiator
//  douta        out  1   serial data, side A
//  doutb        out  1   serial data, side B
//  frame_cnt    out  16  completed-frame counter, wraps 0xFFFF->0
//  short_frame  out  1   one-clock pulse: ncs rose before the word's LSB was shifted
//  rng_latched  out  1   rng sampled at the last ncs falling edge
// BEHAVIOUR
//  Reset (reset_n low, async): douta=doutb=0, frame_cnt=0, short_frame=0, rng_latched=0, FSM=IDLE, tables all 0.
//  All inputs pass through sig_sync; edges detected on synchronized copies. Edge->action latency: SYNC_STAGES+1 clocks.
//  FSM IDLE: dout=0; sclk edges ignored. ncs fall -> latch adc_addr (channel), rng_latched<=rng,
//   load shift regs {LEAD_ZEROS'b0, word_a[ch]}, {.., word_b[ch]}, bit_cnt=0 -> SHIFT.
//  SHIFT: dout = MSB of shift reg (first leading zero visible immediately on entry).
//   Each sclk falling edge: shift left (zero fill), bit_cnt++. At bit_cnt = LEAD_ZEROS+12 -> TRAIL.
//  TRAIL: dout=0, sclk edges ignored until ncs rise.
//  ncs rise in TRAIL: frame_cnt++, -> IDLE. ncs rise in SHIFT: short_frame pulse, frame_cnt unchanged, -> IDLE.
//  adc_addr/rng changes while ncs low: ignored until next ncs fall.
//  sclk falling and ncs rise in same clock: ncs rise wins; the shift is discarded.
//  wr_en during an active frame: table updated; the in-flight shift reg keeps its loaded word.
//  rng has no effect on data (straight binary); only reported via rng_latched.
// CONFIGURATION
//  AD7265_RESP_DITHER_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset) steps
//   once per ncs fall; its bit0 XORs the word LSB at load (A uses bit0, B uses bit1).
//  Not defined: words shifted exactly as written; no LFSR logic present.
// STRUCTURE
//  PFS package: typedef adc_word_t (logic [11:0]), adc_chan_t (logic [2:0]), ADC_NCHAN=8,
//   ADC_WORD_BITS=12, resp_state_t enum {IDLE, SHIFT, TRAIL}.
//  Sub-module: sig_sync (N-stage synchronizer + rise/fall pulse), one instance per input bit group.
//  Tables: two 8x12 register arrays, no RAM inference required.
// TESTING
//  1 Reset: hold reset_n low mid-SHIFT -> douta=doutb=0, FSM IDLE, frame_cnt=0 within same clock.
//  2 Write A[3]=0x678, B[3]=0x987; frame addr=3, 16 sclk -> douta bits 00_0110_0111_1000, doutb 00_1001_1000_0111,
//    zeros after; frame_cnt=1.
//  3 Boundary channels: A[0]=0xFFF, A[7]=0x001; frames addr 0 then 7 -> 0xFFF then 0x001 recovered by capture model.
//  4 Short frame: ncs high after 6 sclk falls -> short_frame one pulse, frame_cnt unchanged, next full frame correct.
//  5 adc_addr change 3->5 mid-frame and wr_en to A[3] mid-frame -> current frame still shifts old A[3]; next frame new.
//  6 Drive full loop with adc_temps_if at 1 MHz sclk for 1000 frames -> its read values equal table; with
//    AD7265_RESP_DITHER_EN, LSB differs per LFSR model, bits 11:1 match.

Source files
------------

// File: rtl/ad7265_responder_pkg.sv
// ad7265_responder_pkg: shared types and sizes for the AD7265 serial responder.
package ad7265_responder_pkg;
    localparam int ADC_NCHAN     = 8;
    localparam int ADC_WORD_BITS = 12;
    typedef logic [ADC_WORD_BITS-1:0] adc_word_t;
    typedef logic [2:0] adc_chan_t;
    typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} resp_state_t;
endpackage

// File: rtl/ad7265_responder_sig_sync.sv
// ad7265_responder_sig_sync: N-stage synchronizer for a W-bit group with rise/fall pulses.
module ad7265_responder_sig_sync #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [N-1:0][W-1:0] chain;
    logic [W-1:0] q_d;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            q_d   <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
            q_d   <= chain[N-1];
        end
    end
    assign q    = chain[N-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/ad7265_responder.sv
// ad7265_responder: device-side AD7265 dual-ADC emulation shifting table words on douta/doutb.
// Optional AD7265_RESP_DITHER_EN: LFSR dither on the loaded word LSBs.
module ad7265_responder
    import ad7265_responder_pkg::*;
#(
    parameter int LEAD_ZEROS  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic        wr_side,
    input  logic [2:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic        adc_sclk,
    input  logic        ncs,
    input  logic [2:0]  adc_addr,
    input  logic        rng,
    output logic        douta,
    output logic        doutb,
    output logic [15:0] frame_cnt,
    output logic        short_frame,
    output logic        rng_latched
);
    localparam int SW = LEAD_ZEROS + ADC_WORD_BITS;
    localparam int CW = $clog2(SW + 1);

    logic sclk_q_unused, sclk_rise_unused, sclk_fall;
    logic ncs_q_unused, ncs_rise, ncs_fall;
    logic [3:0] sel_q, sel_rise_unused, sel_fall_unused;

    ad7265_responder_sig_sync #(.W(1), .N(SYNC_STAGES)) u_sclk (
        .clock(clock), .reset_n(reset_n), .d(adc_sclk),
        .q(sclk_q_unused), .rise(sclk_rise_unused), .fall(sclk_fall));
    ad7265_responder_sig_sync #(.W(1), .N(SYNC_STAGES)) u_ncs (
        .clock(clock), .reset_n(reset_n), .d(ncs),
        .q(ncs_q_unused), .rise(ncs_rise), .fall(ncs_fall));
    ad7265_responder_sig_sync #(.W(4), .N(SYNC_STAGES)) u_sel (
        .clock(clock), .reset_n(reset_n), .d({rng, adc_addr}),
        .q(sel_q), .rise(sel_rise_unused), .fall(sel_fall_unused));

    adc_word_t tab_a [ADC_NCHAN];
    adc_word_t tab_b [ADC_NCHAN];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tab_a <= '{default: '0};
            tab_b <= '{default: '0};
        end else if (wr_en) begin
            if (wr_side) tab_b[wr_addr] <= wr_data;
            else tab_a[wr_addr] <= wr_data;
        end
    end

    logic [1:0] dith;
`ifdef AD7265_RESP_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr <= 16'hACE1;
        else if (ncs_fall) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign dith = lfsr[1:0];
`else
    assign dith = 2'b00;
`endif

    adc_chan_t ch;
    adc_word_t wa, wb;
    assign ch = sel_q[2:0];
    assign wa = {tab_a[ch][11:1], tab_a[ch][0] ^ dith[0]};
    assign wb = {tab_b[ch][11:1], tab_b[ch][0] ^ dith[1]};

    resp_state_t state, state_n;
    logic [SW-1:0] sh_a, sh_b, sh_a_n, sh_b_n;
    logic [CW-1:0] bit_cnt, cnt_n;
    logic [15:0] frame_n;
    logic short_n, rng_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sh_a        <= '0;
            sh_b        <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            short_frame <= 1'b0;
            rng_latched <= 1'b0;
        end else begin
            state       <= state_n;
            sh_a        <= sh_a_n;
            sh_b        <= sh_b_n;
            bit_cnt     <= cnt_n;
            frame_cnt   <= frame_n;
            short_frame <= short_n;
            rng_latched <= rng_n;
        end
    end

    // ncs rise is checked before sclk fall so a coincident shift is dropped
    always_comb begin
        state_n = state;
        sh_a_n  = sh_a;
        sh_b_n  = sh_b;
        cnt_n   = bit_cnt;
        frame_n = frame_cnt;
        short_n = 1'b0;
        rng_n   = rng_latched;
        case (state)
            IDLE: if (ncs_fall) begin
                state_n = SHIFT;
                rng_n   = sel_q[3];
                sh_a_n  = {{LEAD_ZEROS{1'b0}}, wa};
                sh_b_n  = {{LEAD_ZEROS{1'b0}}, wb};
                cnt_n   = '0;
            end
            SHIFT: if (ncs_rise) begin
                state_n = IDLE;
                short_n = 1'b1;
            end else if (sclk_fall) begin
                sh_a_n  = sh_a << 1;
                sh_b_n  = sh_b << 1;
                cnt_n   = bit_cnt + CW'(1);
                state_n = (cnt_n == CW'(SW)) ? TRAIL : SHIFT;
            end
            TRAIL: if (ncs_rise) begin
                state_n = IDLE;
                frame_n = frame_cnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign douta = (state == SHIFT) & sh_a[SW-1];
    assign doutb = (state == SHIFT) & sh_b[SW-1];
endmodule

// File: tb/tb_ad7265_responder.sv
// tb_ad7265_responder: randomized self-checking bench with a table/frame reference model.
module tb_ad7265_responder;
    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_en = 1'b0;
    logic        wr_side = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        adc_sclk = 1'b1;
    logic        ncs = 1'b1;
    logic [2:0]  adc_addr = '0;
    logic        rng = 1'b0;
    logic        douta, doutb, short_frame, rng_latched;
    logic [15:0] frame_cnt;

    ad7265_responder dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_side(wr_side),
        .wr_addr(wr_addr), .wr_data(wr_data), .adc_sclk(adc_sclk), .ncs(ncs),
        .adc_addr(adc_addr), .rng(rng), .douta(douta), .doutb(doutb),
        .frame_cnt(frame_cnt), .short_frame(short_frame), .rng_latched(rng_latched));

    always #25 clock = ~clock;

    int passed = 0;
    int total  = 0;
    logic [11:0] ref_a [8];
    logic [11:0] ref_b [8];
    logic [15:0] exp_frames = '0;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic side, input logic [2:0] a, input logic [11:0] d);
        @(negedge clock);
        wr_en = 1'b1; wr_side = side; wr_addr = a; wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic set_word(input logic side, input logic [2:0] a, input logic [11:0] d);
        wr(side, a, d);
        if (side) ref_b[a] = d;
        else ref_a[a] = d;
    endtask

    // Bits expected on the wire before each of the first nf sclk falls: 2 zeros, word, zeros.
    function automatic logic [15:0] expect_bits(input logic [11:0] w, input int nf);
        logic [15:0] ones;
        ones = 16'hFFFF;
        return ({4'b0000, w} << 2) & ~(ones >> nf);
    endfunction

    // One frame: nf sclk falls; at fall index chg_at, adc_addr/rng are changed and A[ch] is rewritten.
    task automatic run_frame(input logic [2:0] ch, input logic r, input int nf, input int chg_at,
                             input logic [2:0] chg_addr, input logic [11:0] chg_word,
                             output logic [15:0] ca, output logic [15:0] cb, output int pulses);
        adc_addr = ch; rng = r;
        tick(2);
        ncs = 1'b0;
        tick(HALF);
        ca = '0; cb = '0;
        for (int i = 0; i < nf; i++) begin
            if (i == chg_at) begin
                adc_addr = chg_addr; rng = ~r;
                wr(1'b0, ch, chg_word);
            end
            ca[15-i] = douta; cb[15-i] = doutb;
            adc_sclk = 1'b0;
            tick(HALF);
            adc_sclk = 1'b1;
            tick(HALF);
        end
        ncs = 1'b1;
        pulses = 0;
        repeat (HALF) begin
            @(negedge clock);
            if (short_frame) pulses++;
        end
    endtask

    task automatic test_reset;
        total += 5;
        if (douta !== 1'b0) $display("FAIL reset_douta got %b want 0", douta); else passed++;
        if (doutb !== 1'b0) $display("FAIL reset_doutb got %b want 0", doutb); else passed++;
        if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); else passed++;
        if (short_frame !== 1'b0) $display("FAIL reset_short got %b want 0", short_frame); else passed++;
        if (rng_latched !== 1'b0) $display("FAIL reset_rng got %b want 0", rng_latched); else passed++;
    endtask

    task automatic check_frame(input string nm, input logic [2:0] ch, input logic r, input int nf,
                               input logic [15:0] ca, input logic [15:0] cb, input int pulses);
        logic [15:0] ea, eb;
        ea = expect_bits(ref_a[ch], nf);
        eb = expect_bits(ref_b[ch], nf);
        if (nf >= 14) exp_frames = exp_frames + 16'd1;
        total += 5;
        if (ca !== ea) $display("FAIL %s_douta got %h want %h", nm, ca, ea); else passed++;
        if (cb !== eb) $display("FAIL %s_doutb got %h want %h", nm, cb, eb); else passed++;
        if (pulses !== ((nf < 14) ? 1 : 0)) $display("FAIL %s_short got %0d want %0d", nm, pulses, (nf < 14) ? 1 : 0); else passed++;
        if (frame_cnt !== exp_frames) $display("FAIL %s_frame_cnt got %0d want %0d", nm, frame_cnt, exp_frames); else passed++;
        if (rng_latched !== r) $display("FAIL %s_rng got %b want %b", nm, rng_latched, r); else passed++;
    endtask

    task automatic test_known_word;
        logic [15:0] ca, cb;
        int p;
        set_word(1'b0, 3'd3, 12'h678);
        set_word(1'b1, 3'd3, 12'h987);
        run_frame(3'd3, 1'b1, 16, -1, 3'd0, 12'h0, ca, cb, p);
        total += 2;
        if (ca !== 16'b00_0110_0111_1000_00) $display("FAIL known_a got %b want 0001100111100000", ca); else passed++;
        if (cb !== 16'b00_1001_1000_0111_00) $display("FAIL known_b got %b want 0010011000011100", cb); else passed++;
        check_frame("known", 3'd3, 1'b1, 16, ca, cb, p);
    endtask

    task automatic test_boundary_channels;
        logic [15:0] ca, cb;
        int p;
        set_word(1'b0, 3'd0, 12'hFFF);
        set_word(1'b0, 3'd7, 12'h001);
        set_word(1'b1, 3'd0, 12'h800);
        set_word(1'b1, 3'd7, 12'hFFE);
        run_frame(3'd0, 1'b0, 16, -1, 3'd0, 12'h0, ca, cb, p);
        check_frame("ch0", 3'd0, 1'b0, 16, ca, cb, p);
        run_frame(3'd7, 1'b1, 16, -1, 3'd0, 12'h0, ca, cb, p);
        check_frame("ch7", 3'd7, 1'b1, 16, ca, cb, p);
    endtask

    task automatic test_short_frame;
        logic [15:0] ca, cb;
        int p;
        set_word(1'b0, 3'd2, 12'($urandom));
        set_word(1'b1, 3'd2, 12'($urandom));
        run_frame(3'd2, 1'b1, 6, -1, 3'd0, 12'h0, ca, cb, p);
        check_frame("short", 3'd2, 1'b1, 6, ca, cb, p);
        run_frame(3'd2, 1'b0, 16, -1, 3'd0, 12'h0, ca, cb, p);
        check_frame("after_short", 3'd2, 1'b0, 16, ca, cb, p);
    endtask

    task automatic test_midframe_changes;
        logic [15:0] ca, cb;
        int p;
        set_word(1'b0, 3'd5, 12'h155);
        set_word(1'b1, 3'd5, 12'h2AA);
        run_frame(3'd3, 1'b0, 16, 5, 3'd5, 12'hABC, ca, cb, p);
        check_frame("mid_old", 3'd3, 1'b0, 16, ca, cb, p);
        ref_a[3] = 12'hABC;
        run_frame(3'd3, 1'b1, 16, -1, 3'd0, 12'h0, ca, cb, p);
        check_frame("mid_new", 3'd3, 1'b1, 16, ca, cb, p);
    endtask

    task automatic test_random_frames;
        logic [15:0] ca, cb;
        int p, nf, chg;
        logic [2:0] ch;
        logic r;
        logic [11:0] cw;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) set_word(1'($urandom), 3'($urandom), 12'($urandom));
            ch  = 3'($urandom);
            r   = 1'($urandom);
            nf  = $urandom_range(1, 16);
            chg = $urandom_range(0, nf);
            cw  = 12'($urandom);
            run_frame(ch, r, nf, chg, 3'($urandom), cw, ca, cb, p);
            check_frame("rand", ch, r, nf, ca, cb, p);
            if (chg < nf) ref_a[ch] = cw;
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [15:0] ca, cb;
        int p;
        set_word(1'b0, 3'd1, 12'hFFF);
        set_word(1'b1, 3'd1, 12'hFFF);
        adc_addr = 3'd1;
        tick(2);
        ncs = 1'b0;
        tick(HALF);
        repeat (3) begin
            adc_sclk = 1'b0; tick(HALF);
            adc_sclk = 1'b1; tick(HALF);
        end
        total += 2;
        if (douta !== 1'b1) $display("FAIL pre_reset_douta got %b want 1", douta); else passed++;
        if (frame_cnt !== exp_frames) $display("FAIL pre_reset_frame_cnt got %0d want %0d", frame_cnt, exp_frames); else passed++;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total += 3;
        if (douta !== 1'b0) $display("FAIL async_reset_douta got %b want 0", douta); else passed++;
        if (doutb !== 1'b0) $display("FAIL async_reset_doutb got %b want 0", doutb); else passed++;
        if (frame_cnt !== 16'd0) $display("FAIL async_reset_frame_cnt got %0d want 0", frame_cnt); else passed++;
        ncs = 1'b1; adc_sclk = 1'b1;
        tick(3);
        reset_n = 1'b1;
        foreach (ref_a[i]) begin ref_a[i] = '0; ref_b[i] = '0; end
        exp_frames = '0;
        tick(5);
        run_frame(3'd1, 1'b0, 16, -1, 3'd0, 12'h0, ca, cb, p);
        check_frame("post_reset", 3'd1, 1'b0, 16, ca, cb, p);
    endtask

    initial begin
        foreach (ref_a[i]) begin ref_a[i] = '0; ref_b[i] = '0; end
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(6);
        test_reset;
        test_known_word;
        test_boundary_channels;
        test_short_frame;
        test_midframe_changes;
        test_random_frames;
        test_reset_mid_shift;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
